sram_responder: RTL
===================

Name: sram_responder

Overview:
- Responder (slave) end of the CPU's single-cycle SRAM-style interface: en / we[3:0] / addr / wdata out from the core, rdata back.
- Serves a word-addressed RAM with byte-lane writes, plus a small MMIO window: LED register, free-running timer, scratch register.
- Instantiated in the SoC/testbench wrapper beside the core, one instance per port (instruction and data).
- Instruction port instance ties we to 0.

Parameters:
- ADDR_W, 14, RAM depth is 2**ADDR_W 32-bit words.
- MMIO_BASE, 32'hbfaf_0000, MMIO window base; bits [31:16] select the window.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- sram_en  input  1  access request this cycle
- sram_we  input  4  byte write enables; 0 = read
- sram_addr  input  32  byte address; [1:0] ignored
- sram_wdata  input  32  write data, lane i = bits [8i+7:8i]
- sram_rdata  output  32  read data, valid the cycle after the read request
- led  output  16  LED register contents
- timer  output  32  current timer value
- access_cnt  output  32  count of accepted accesses (reads + writes)

Behaviour:
- Reset (async, active-high): sram_rdata=0, led=0, timer=0, scratch=0, access_cnt=0. RAM contents are not reset.
- Decode:
  - mmio_hit = (sram_addr[31:16] == MMIO_BASE[31:16]).
  - Otherwise RAM, with word index = sram_addr[ADDR_W+1:2]. Upper bits are ignored, so addresses alias.
- Read (sram_en=1, sram_we=0):
  - sram_rdata is registered at the next rising edge; fixed latency 1.
  - sram_rdata holds that value until the next read.
- Write (sram_en=1, sram_we!=0):
  - Only enabled lanes update at the rising edge.
  - sram_rdata keeps its previous value.
  - No read-modify-write hazard exists.
- Idle (sram_en=0): no state change except timer; sram_rdata holds.
- Back-to-back write then read of the same word: the read returns the newly written bytes, because the write commits at the earlier edge.
- MMIO offsets (sram_addr[15:0]):
  - 0x0000 LED: rw; bits [15:0] stored, upper bits read 0; byte lanes 2/3 ignored on write.
  - 0x0004 TIMER: read returns the timer value sampled in the request cycle. Write loads the enabled lanes.
  - 0x0008 SCRATCH: rw, full 32 bits, byte-lane writes.
  - Any other offset: reads return 0, writes are dropped.
- Timer:
  - Increments by 1 every cycle and wraps 32'hffff_ffff -> 0.
  - A write in the same cycle wins over the increment: the next value is the written value (merged with old bytes on disabled lanes), not +1.
  - It increments from the written value on the following cycle.
- access_cnt increments by 1 on every cycle with sram_en=1, wraps at 2**32.
- Reset asserted mid-access: that access is discarded. A RAM write in the reset cycle may or may not commit; verification must not check it.
- Unknown/X on sram_we while sram_en=0 has no effect.

Decomposition:
- Shared package sram_resp_pkg:
  - MMIO offset constants LED_OFF=16'h0000, TIMER_OFF=16'h0004, SCRATCH_OFF=16'h0008.
  - A byte-merge function: old, new, we -> merged word.
- One sub-module, byte_we_ram:
  - Synchronous single-port RAM, parameter ADDR_W, 4 byte-write enables, registered read, no reset.
- sram_responder holds the decode, MMIO registers, timer, counter and read mux.

Test Plan:
- Reset, then write addr 0x0000_0010 we=4'hf data 0x1234_5678, then read it -> sram_rdata=0x1234_5678 one cycle after the read request; access_cnt=2.
- Partial write we=4'b0101 data 0xAABB_CCDD onto word 0x1234_5678 -> readback 0x12BB_56DD.
- Write LED (addr 0xbfaf_0000) data 0xdead_beef we=4'hf -> led=16'hbeef; readback 0x0000_beef. Read offset 0x000c -> 0.
- Write TIMER data 0xffff_fffe with the timer running -> timer=0xffff_fffe the next cycle, 0xffff_ffff after that, then 0x0000_0000 (wrap).
- Read word 0 then idle for 3 cycles, then write -> sram_rdata unchanged through the idle and write cycles. Assert reset during a read -> sram_rdata=0 immediately (asynchronous) and access_cnt=0.
- Aliasing with ADDR_W=14: write 0x0001_0000, read 0x0000_0000 -> same data.

Source files
------------

// File: rtl/sram_resp_pkg.sv
// rtl/sram_resp_pkg.sv - shared constants, read-source enum and byte-merge helper for sram_responder
package sram_resp_pkg;

  localparam logic [15:0] LED_OFF     = 16'h0000;
  localparam logic [15:0] TIMER_OFF   = 16'h0004;
  localparam logic [15:0] SCRATCH_OFF = 16'h0008;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_MMIO
  } rd_src_t;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  we
  );
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/byte_we_ram.sv
// rtl/byte_we_ram.sv - single-port word RAM with byte-lane writes and a registered read port
module byte_we_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // rdata only moves on a read, so it naturally holds across writes and idle cycles
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - SRAM-style responder: word RAM plus LED/timer/scratch MMIO window
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  output logic [31:0] timer,
  output logic [31:0] access_cnt
);

  logic        mmio_hit;
  logic        acc_rd;
  logic        mmio_wr;
  logic        ram_en;
  logic [15:0] off;
  logic [31:0] scratch;
  logic [31:0] mmio_rdata;
  logic [31:0] mmio_q;
  logic [31:0] ram_q;
  rd_src_t     rd_src;

  assign mmio_hit = (sram_addr[31:16] == MMIO_BASE[31:16]);
  assign off      = sram_addr[15:0];
  assign acc_rd   = sram_en && (sram_we == 4'b0000);
  assign mmio_wr  = sram_en && (sram_we != 4'b0000) && mmio_hit;
  assign ram_en   = sram_en && !mmio_hit;

  byte_we_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (sram_we),
    .addr (sram_addr[ADDR_W+1:2]),
    .wdata(sram_wdata),
    .rdata(ram_q)
  );

  always_comb begin
    mmio_rdata = 32'h0;
    case (off)
      LED_OFF:     mmio_rdata = {16'h0, led};
      TIMER_OFF:   mmio_rdata = timer;
      SCRATCH_OFF: mmio_rdata = scratch;
      default:     mmio_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led        <= 16'h0;
      timer      <= 32'h0;
      scratch    <= 32'h0;
      access_cnt <= 32'h0;
      mmio_q     <= 32'h0;
      rd_src     <= SRC_NONE;
    end else begin
      if (sram_en) access_cnt <= access_cnt + 32'd1;

      // a timer write overrides this cycle's increment
      if (mmio_wr && off == TIMER_OFF) timer <= merge_bytes(timer, sram_wdata, sram_we);
      else                             timer <= timer + 32'd1;

      if (mmio_wr && off == LED_OFF) begin
        if (sram_we[0]) led[7:0]  <= sram_wdata[7:0];
        if (sram_we[1]) led[15:8] <= sram_wdata[15:8];
      end

      if (mmio_wr && off == SCRATCH_OFF) scratch <= merge_bytes(scratch, sram_wdata, sram_we);

      if (acc_rd) begin
        rd_src <= mmio_hit ? SRC_MMIO : SRC_RAM;
        if (mmio_hit) mmio_q <= mmio_rdata;
      end
    end
  end

  // the RAM's read register has no reset, so the source tag forces 0 until the first read
  always_comb begin
    sram_rdata = 32'h0;
    case (rd_src)
      SRC_RAM:  sram_rdata = ram_q;
      SRC_MMIO: sram_rdata = mmio_q;
      default:  sram_rdata = 32'h0;
    endcase
  end

endmodule
